// File: rtl/seg7_pkg.sv
// Shared definitions for the active-low 7-segment display readback blocks.
package seg7_pkg;

    // All segments off: the digit is intentionally blank.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low segment patterns for hex digits 0..F, ordered a..g in bits 6..0.
    localparam logic [6:0] HEX_TABLE [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06,
        7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h0C, 7'h08, 7'h60,
        7'h31, 7'h42, 7'h30, 7'h38
    };

    // TRACK waits for a settled digit; HOLD blocks re-acceptance until the bus changes.
    typedef enum logic {
        TRACK,
        HOLD
    } state_t;

endpackage

// File: rtl/seg7_pattern_dec.sv
// Combinational inverse of the hex-to-segment path: active-low pattern to nibble.
module seg7_pattern_dec
    import seg7_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic [3:0] nibble,
    output logic       is_hex,
    output logic       is_blank
);

    // Search the hex table; blank and unknown patterns both report nibble 0.
    always_comb begin
        nibble   = 4'h0;
        is_hex   = 1'b0;
        is_blank = (seg_n == SEG_BLANK);
        for (int k = 0; k < 16; k++) begin
            if (seg_n == HEX_TABLE[k]) begin
                nibble = k[3:0];
                is_hex = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Display bus monitor: samples a multiplexed active-low 7-segment bus, waits for each
// digit to settle, decodes it and reassembles the full word once every digit is seen.
module seven_seg_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [6:0]                    seg_n,
    input  logic [NUM_DIGITS-1:0]         an_n,
    output logic [4*NUM_DIGITS-1:0]       value,
    output logic [NUM_DIGITS-1:0]         blank_mask,
    output logic                          frame_valid,
    output logic                          pattern_err,
    output logic [$clog2(NUM_DIGITS)-1:0] err_digit
);

    localparam int         IDXW    = $clog2(NUM_DIGITS);
    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

    logic [6:0]            r_segMeta;
    logic [6:0]            r_segSync;
    logic [6:0]            r_segPrev;
    logic [NUM_DIGITS-1:0] r_anMeta;
    logic [NUM_DIGITS-1:0] r_anSync;
    logic [NUM_DIGITS-1:0] r_anPrev;
    logic [7:0]            r_stabCnt;
    state_t                r_state;
    logic [3:0]            r_digits [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] r_blankRegs;
    logic [NUM_DIGITS-1:0] r_seen;
    logic [4*NUM_DIGITS-1:0] r_value;
    logic [NUM_DIGITS-1:0] r_blankMask;
    logic                  r_frameValid;
    logic                  r_patternErr;
    logic [IDXW-1:0]       r_errDigit;

    int                    w_zeroCount;
    logic                  w_anValid;
    logic                  w_stable;
    logic                  w_accept;
    logic [IDXW-1:0]       w_accIdx;
    logic [4*NUM_DIGITS-1:0] w_digitWord;
    logic [3:0]            w_nibble;
    logic                  w_isHex;
    logic                  w_isBlank;

    // Two-flop synchronizer on the asynchronous display pins, plus the previous sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_segMeta <= '1;
            r_segSync <= '1;
            r_segPrev <= '1;
            r_anMeta  <= '1;
            r_anSync  <= '1;
            r_anPrev  <= '1;
        end else begin
            r_segMeta <= seg_n;
            r_segSync <= r_segMeta;
            r_segPrev <= r_segSync;
            r_anMeta  <= an_n;
            r_anSync  <= r_anMeta;
            r_anPrev  <= r_anSync;
        end
    end

    // A sample is usable only when exactly one digit enable is asserted.
    always_comb begin
        w_zeroCount = 0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!r_anSync[i]) begin
                w_zeroCount = w_zeroCount + 1;
            end
        end
    end

    assign w_anValid = (w_zeroCount == 1);
    assign w_stable  = w_anValid && (r_anSync == r_anPrev) && (r_segSync == r_segPrev);
    assign w_accept  = (r_state == TRACK) && (r_stabCnt == CNT_MAX);

    // Count consecutive identical samples; any change or ghosted anode restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stabCnt <= '0;
        end else if (!w_stable) begin
            r_stabCnt <= '0;
        end else if (r_stabCnt != CNT_MAX) begin
            r_stabCnt <= r_stabCnt + 8'd1;
        end
    end

    // The settled pattern lives in the previous-sample register when it is accepted.
    always_comb begin
        w_accIdx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!r_anPrev[i]) begin
                w_accIdx = i[IDXW-1:0];
            end
        end
    end

    seg7_pattern_dec u_patternDec (
        .seg_n    (r_segPrev),
        .nibble   (w_nibble),
        .is_hex   (w_isHex),
        .is_blank (w_isBlank)
    );

    // Flatten the per-digit registers into the output word, digit 0 in the low nibble.
    always_comb begin
        w_digitWord = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_digitWord[4*i +: 4] = r_digits[i];
        end
    end

    // Acceptance FSM with digit storage, error reporting and frame publication.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= TRACK;
            r_digits     <= '{default: '0};
            r_blankRegs  <= '0;
            r_seen       <= '0;
            r_value      <= '0;
            r_blankMask  <= '0;
            r_frameValid <= 1'b0;
            r_patternErr <= 1'b0;
            r_errDigit   <= '0;
        end else begin
            r_frameValid <= 1'b0;
            r_patternErr <= 1'b0;
            if (r_seen == '1) begin
                r_value      <= w_digitWord;
                r_blankMask  <= r_blankRegs;
                r_frameValid <= 1'b1;
                r_seen       <= '0;
            end
            case (r_state)
                TRACK: begin
                    if (w_accept) begin
                        if (w_isHex || w_isBlank) begin
                            r_digits[w_accIdx]    <= w_nibble;
                            r_blankRegs[w_accIdx] <= w_isBlank;
                            r_seen[w_accIdx]      <= 1'b1;
                        end else begin
                            r_patternErr <= 1'b1;
                            r_errDigit   <= w_accIdx;
                        end
                        r_state <= w_stable ? HOLD : TRACK;
                    end
                end
                HOLD: begin
                    if (!w_stable) begin
                        r_state <= TRACK;
                    end
                end
                default: r_state <= TRACK;
            endcase
        end
    end

    assign value       = r_value;
    assign blank_mask  = r_blankMask;
    assign frame_valid = r_frameValid;
    assign pattern_err = r_patternErr;
    assign err_digit   = r_errDigit;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Directed bench for the display readback decoder and its pattern decoder sub-block.
module tb_seven_seg_scan_decoder;

    logic        clk;
    logic        rst;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic [15:0] value;
    logic [3:0]  blank_mask;
    logic        frame_valid;
    logic        pattern_err;
    logic [1:0]  err_digit;

    logic [6:0]  decSeg;
    logic [3:0]  decNibble;
    logic        decIsHex;
    logic        decIsBlank;

    int          assertCount = 0;
    int          failCount   = 0;
    int          frameCount  = 0;
    int          errCount    = 0;
    logic [15:0] lastValue   = '0;
    logic [3:0]  lastBlank   = '0;
    logic [1:0]  lastErrDigit = '0;

    typedef struct {
        logic [6:0] seg;
        logic [3:0] nib;
        logic       hex;
        logic       blank;
    } decVec_t;

    typedef struct {
        logic [3:0][6:0] segs;
        logic [15:0]     expValue;
        logic [3:0]      expBlank;
        int              holdCycles;
    } frameVec_t;

    decVec_t   decTable [17];
    frameVec_t frameTable [5];

    seven_seg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_n       (seg_n),
        .an_n        (an_n),
        .value       (value),
        .blank_mask  (blank_mask),
        .frame_valid (frame_valid),
        .pattern_err (pattern_err),
        .err_digit   (err_digit)
    );

    seg7_pattern_dec uDec (
        .seg_n    (decSeg),
        .nibble   (decNibble),
        .is_hex   (decIsHex),
        .is_blank (decIsBlank)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every output pulse away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_valid) begin
                frameCount = frameCount + 1;
                lastValue  = value;
                lastBlank  = blank_mask;
            end
            if (pattern_err) begin
                errCount     = errCount + 1;
                lastErrDigit = err_digit;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] an, input logic [6:0] seg, input int cycles);
        @(negedge clk);
        an_n  = an;
        seg_n = seg;
        repeat (cycles) @(posedge clk);
    endtask

    function automatic logic [3:0] anFor(input int d);
        logic [3:0] a;
        a    = 4'b1111;
        a[d] = 1'b0;
        return a;
    endfunction

    task automatic idleBus(input int cycles);
        applyStimulus(4'b1111, 7'h7F, cycles);
    endtask

    initial begin
        int prevFrames;
        int prevErrs;
        logic found;
        logic expHex;
        logic expBlank;

        rst    = 1'b1;
        an_n   = 4'b1111;
        seg_n  = 7'h7F;
        decSeg = 7'h7F;

        decTable[0]  = '{7'h01, 4'h0, 1'b1, 1'b0};
        decTable[1]  = '{7'h4F, 4'h1, 1'b1, 1'b0};
        decTable[2]  = '{7'h12, 4'h2, 1'b1, 1'b0};
        decTable[3]  = '{7'h06, 4'h3, 1'b1, 1'b0};
        decTable[4]  = '{7'h4C, 4'h4, 1'b1, 1'b0};
        decTable[5]  = '{7'h24, 4'h5, 1'b1, 1'b0};
        decTable[6]  = '{7'h20, 4'h6, 1'b1, 1'b0};
        decTable[7]  = '{7'h0F, 4'h7, 1'b1, 1'b0};
        decTable[8]  = '{7'h00, 4'h8, 1'b1, 1'b0};
        decTable[9]  = '{7'h0C, 4'h9, 1'b1, 1'b0};
        decTable[10] = '{7'h08, 4'hA, 1'b1, 1'b0};
        decTable[11] = '{7'h60, 4'hB, 1'b1, 1'b0};
        decTable[12] = '{7'h31, 4'hC, 1'b1, 1'b0};
        decTable[13] = '{7'h42, 4'hD, 1'b1, 1'b0};
        decTable[14] = '{7'h30, 4'hE, 1'b1, 1'b0};
        decTable[15] = '{7'h38, 4'hF, 1'b1, 1'b0};
        decTable[16] = '{7'h7F, 4'h0, 1'b0, 1'b1};

        frameTable[0] = '{{7'h01, 7'h4F, 7'h12, 7'h06}, 16'h0123, 4'b0000, 64};
        frameTable[1] = '{{7'h7F, 7'h30, 7'h42, 7'h00}, 16'h0ED8, 4'b1000, 30};
        frameTable[2] = '{{7'h08, 7'h60, 7'h31, 7'h42}, 16'hABCD, 4'b0000, 30};
        frameTable[3] = '{{7'h7F, 7'h7F, 7'h7F, 7'h7F}, 16'h0000, 4'b1111, 30};
        frameTable[4] = '{{7'h0F, 7'h24, 7'h0C, 7'h38}, 16'h759F, 4'b0000, 30};

        #2;
        checkOutput("reset value", 32'(value), 32'h0);
        checkOutput("reset blank_mask", 32'(blank_mask), 32'h0);
        checkOutput("reset frame_valid", 32'(frame_valid), 32'h0);
        checkOutput("reset pattern_err", 32'(pattern_err), 32'h0);
        checkOutput("reset err_digit", 32'(err_digit), 32'h0);

        // Pattern decoder: legal table entries and blank.
        for (int v = 0; v < 17; v++) begin
            decSeg = decTable[v].seg;
            #1;
            checkOutput($sformatf("dec nibble %02h", decTable[v].seg), 32'(decNibble), 32'(decTable[v].nib));
            checkOutput($sformatf("dec is_hex %02h", decTable[v].seg), 32'(decIsHex), 32'(decTable[v].hex));
            checkOutput($sformatf("dec is_blank %02h", decTable[v].seg), 32'(decIsBlank), 32'(decTable[v].blank));
        end

        // Pattern decoder: every other code must be rejected.
        for (int c = 0; c < 128; c++) begin
            found    = 1'b0;
            expHex   = 1'b0;
            expBlank = 1'b0;
            for (int v = 0; v < 17; v++) begin
                if (decTable[v].seg == c[6:0]) found = 1'b1;
            end
            if (!found) begin
                decSeg = c[6:0];
                #1;
                checkOutput($sformatf("dec illegal is_hex %02h", c), 32'(decIsHex), 32'(expHex));
                checkOutput($sformatf("dec illegal is_blank %02h", c), 32'(decIsBlank), 32'(expBlank));
            end
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idleBus(5);

        // Full frames from the table, digit 0 scanned first.
        for (int f = 0; f < 5; f++) begin
            prevFrames = frameCount;
            prevErrs   = errCount;
            for (int d = 0; d < 4; d++) begin
                applyStimulus(anFor(d), frameTable[f].segs[d], frameTable[f].holdCycles);
            end
            idleBus(20);
            checkOutput($sformatf("frame %0d count", f), 32'(frameCount), 32'(prevFrames + 1));
            checkOutput($sformatf("frame %0d value", f), 32'(lastValue), 32'(frameTable[f].expValue));
            checkOutput($sformatf("frame %0d blank_mask", f), 32'(lastBlank), 32'(frameTable[f].expBlank));
            checkOutput($sformatf("frame %0d value port", f), 32'(value), 32'(frameTable[f].expValue));
            checkOutput($sformatf("frame %0d no pattern_err", f), 32'(errCount), 32'(prevErrs));
        end

        // Illegal pattern on digit 2 blocks the frame until a legal digit 2 arrives.
        prevFrames = frameCount;
        prevErrs   = errCount;
        applyStimulus(anFor(0), 7'h4F, 30);
        applyStimulus(anFor(1), 7'h12, 30);
        applyStimulus(anFor(3), 7'h4C, 30);
        applyStimulus(anFor(2), 7'h7E, 20);
        idleBus(20);
        checkOutput("illegal err pulses", 32'(errCount), 32'(prevErrs + 1));
        checkOutput("illegal err_digit", 32'(lastErrDigit), 32'h2);
        checkOutput("illegal err_digit port", 32'(err_digit), 32'h2);
        checkOutput("illegal no frame", 32'(frameCount), 32'(prevFrames));
        applyStimulus(anFor(2), 7'h24, 30);
        idleBus(20);
        checkOutput("recovered frame count", 32'(frameCount), 32'(prevFrames + 1));
        checkOutput("recovered frame value", 32'(lastValue), 32'h4521);

        // Stability threshold: one sample short is ignored, exactly enough is accepted.
        prevErrs = errCount;
        applyStimulus(anFor(1), 7'h7E, 7);
        idleBus(20);
        checkOutput("short hold ignored", 32'(errCount), 32'(prevErrs));
        applyStimulus(anFor(1), 7'h7E, 8);
        idleBus(20);
        checkOutput("exact hold accepted", 32'(errCount), 32'(prevErrs + 1));
        checkOutput("exact hold err_digit", 32'(err_digit), 32'h1);
        prevErrs   = errCount;
        prevFrames = frameCount;
        applyStimulus(4'b1100, 7'h7E, 50);
        idleBus(20);
        checkOutput("two anodes ignored", 32'(errCount), 32'(prevErrs));
        checkOutput("two anodes no frame", 32'(frameCount), 32'(prevFrames));

        // Re-acceptance within a frame: the later digit 0 value wins.
        prevFrames = frameCount;
        applyStimulus(anFor(0), 7'h24, 30);
        applyStimulus(anFor(1), 7'h20, 30);
        applyStimulus(anFor(0), 7'h08, 30);
        applyStimulus(anFor(2), 7'h01, 30);
        applyStimulus(anFor(3), 7'h38, 30);
        idleBus(20);
        checkOutput("reaccept frame count", 32'(frameCount), 32'(prevFrames + 1));
        checkOutput("reaccept frame value", 32'(lastValue), 32'hF06A);

        // Reset after three of four digits discards the partial frame.
        prevFrames = frameCount;
        applyStimulus(anFor(0), 7'h0C, 30);
        applyStimulus(anFor(1), 7'h0C, 30);
        applyStimulus(anFor(2), 7'h0C, 30);
        @(negedge clk);
        an_n  = 4'b1111;
        seg_n = 7'h7F;
        rst   = 1'b1;
        #1;
        checkOutput("midreset value", 32'(value), 32'h0);
        checkOutput("midreset blank_mask", 32'(blank_mask), 32'h0);
        checkOutput("midreset err_digit", 32'(err_digit), 32'h0);
        checkOutput("midreset frame_valid", 32'(frame_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(anFor(3), 7'h4C, 30);
        idleBus(20);
        checkOutput("postreset partial no frame", 32'(frameCount), 32'(prevFrames));
        applyStimulus(anFor(0), 7'h4F, 30);
        applyStimulus(anFor(1), 7'h12, 30);
        applyStimulus(anFor(2), 7'h06, 30);
        idleBus(20);
        checkOutput("postreset frame count", 32'(frameCount), 32'(prevFrames + 1));
        checkOutput("postreset frame value", 32'(lastValue), 32'h4321);
        checkOutput("postreset blank_mask", 32'(lastBlank), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_decoder.md
Name: seven_seg_scan_decoder

Overview:
- Recovers hex values from a time-multiplexed, active-low 7-segment display bus: segment lines plus per-digit anode enables.
- Inverse of the hex-to-segment path. Used as a display monitor/loopback checker so the processor bench and on-chip self-test can read back what the display shows.
- Reassembles a full NUM_DIGITS word once every digit has been seen stable. Flags undecodable patterns.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; anode width; value = 4*NUM_DIGITS bits.
- STABLE_CYCLES, 8, consecutive identical samples required before a digit is accepted (legal range 2..255).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- seg_n  input  7  active-low segments; bit6=a, 5=b, 4=c, 3=d, 2=e, 1=f, 0=g
- an_n  input  NUM_DIGITS  active-low digit enables; bit i = digit i (digit 0 = least significant nibble)
- value  output  4*NUM_DIGITS  last complete decoded word
- blank_mask  output  NUM_DIGITS  bit i=1 means digit i was blank (seg_n=7'h7F); its nibble reads 0
- frame_valid  output  1  one-cycle pulse when value/blank_mask update
- pattern_err  output  1  one-cycle pulse when a stable, undecodable pattern is seen
- err_digit  output  $clog2(NUM_DIGITS)  index of the digit that caused the last pattern_err

Behaviour:
- Reset (async, active-high):
  - value=0, blank_mask=0, frame_valid=0, pattern_err=0, err_digit=0.
  - Synchronizers=all ones (idle bus), stab_cnt=0, seen mask=0, state=TRACK.
- Input sampling:
  - seg_n and an_n pass a 2-flop synchronizer; "sample" means the second-stage output.
  - The previous sample is also registered for comparison.
- Stability counter:
  - An anode is valid when exactly one bit of sampled an_n is 0.
  - stab_cnt increments (saturating at STABLE_CYCLES-1) when the anode is valid and (an,seg) equals the previous sample.
  - Otherwise stab_cnt is cleared to 0.
- FSM (2 states):
  - TRACK: when stab_cnt==STABLE_CYCLES-1, accept the digit and go to HOLD.
  - HOLD: no further acceptance. Any change in (an,seg), or an invalid anode, goes to TRACK with stab_cnt=0.
- Acceptance of digit i with pattern p:
  - p in the hex table: store the nibble into digit reg i, clear blank bit i, set seen[i].
  - p==7'h7F: store nibble 0, set blank bit i, set seen[i].
  - Anything else: pattern_err=1 for one cycle, err_digit=i, seen[i] unchanged, digit reg i unchanged.
- Hex table (active-low, seg_n[6:0]):
  - 0=01, 1=4F, 2=12, 3=06, 4=4C, 5=24, 6=20, 7=0F
  - 8=00, 9=0C, A=08, b=60, C=31, d=42, E=30, F=38
- Frame completion:
  - Occurs on the cycle after the acceptance that makes seen all ones, counting that acceptance itself.
  - value and blank_mask load from the digit regs, including the just-accepted digit. frame_valid=1 for one cycle. seen clears to 0.
  - Digit regs are not cleared.
- Re-acceptance: a digit accepted again before the frame completes overwrites its reg; last value wins.
- Latency: the first accepted edge occurs 2 (sync) + STABLE_CYCLES cycles after a new pattern appears on the pins. frame_valid follows the final digit acceptance by one cycle.
- Ghosting/transitions: anode and segment changes on different cycles reset the count. Only the settled pattern is accepted.
- Reset mid-operation: immediately returns to the reset state. A partial frame is discarded with no frame_valid.

Decomposition:
- Package seg7_pkg:
  - SEG_BLANK=7'h7F.
  - A 16-entry localparam array of active-low hex patterns.
  - Enum state_t {TRACK, HOLD}.
- Sub-module seg7_pattern_dec: combinational, seg_n[6:0] -> nibble[3:0], is_hex, is_blank. It is shared with future display blocks and tested standalone.

Test Plan:
- Each digit i shows (3-i), one digit at a time, 64 cycles per digit (an_n=1110,1101,1011,0111) -> one frame_valid, value=16'h0123, blank_mask=0, no pattern_err.
- Cycle all 16 table patterns plus 7'h7F through seg7_pattern_dec -> correct nibble/is_hex/is_blank. The other 111 patterns -> is_hex=0 and is_blank=0.
- Digit 2 seg_n=7'h7E stable for 20 cycles -> one pattern_err pulse, err_digit=2, no frame_valid until digit 2 shows a legal pattern.
- Pattern held only STABLE_CYCLES-1 samples, then changed -> no acceptance. Held exactly STABLE_CYCLES -> accepted. an_n=4'b1100 held 50 cycles -> never accepted.
- Full frame with digit 3 blank (7'h7F) and digits 2..0 = 'E','d','8' -> value=16'h0ED8, blank_mask=4'b1000.
- Assert rst for 1 cycle after 3 of 4 digits are accepted -> outputs back to 0, no frame_valid. After a fresh 4-digit scan, the next frame_valid carries only post-reset values.
